// File: rtl/toeplitz_acc.sv
// Streaming Toeplitz hash: column j is XORed into the accumulator when input bit j is set.
// Define TOEPLITZ_ACC_OVERLAP_EN to keep accumulating the next block while the hash is held.
module toeplitz_acc #(
    parameter int unsigned BS = 64,
    parameter int unsigned N  = 256,
    parameter int unsigned L  = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BS-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [L-1:0]  col,
    input  logic          col_valid,
    output logic          col_ready,
    output logic [L-1:0]  hash,
    output logic          hash_valid,
    input  logic          hash_ready
);

    localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = (BS > 1) ? $clog2(BS) : 1;
    localparam logic [JW-1:0] JLast = JW'(N - 1);
    localparam logic [BW-1:0] BLast = BW'(BS - 1);

    if (N % BS != 0) begin : gen_bad_n
        $error("toeplitz_acc: N must be a multiple of BS");
    end

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e        state_q;
    logic [BS-1:0] word_q;
    logic [BW-1:0] b_q;
    logic [JW-1:0] j_q;
    logic [L-1:0]  acc_q;
    logic [L-1:0]  hash_q;
    logic          hash_valid_q;

    logic          last_col;
    logic          last_bit;
    logic          col_hs;
    logic          din_hs;
    logic          hash_hs;
    logic [L-1:0]  acc_upd;

    assign last_col = (j_q == JLast);
    assign last_bit = (b_q == BLast);

`ifdef TOEPLITZ_ACC_OVERLAP_EN
    // Only the block-completing column must wait for the previous hash to drain.
    assign col_ready = (state_q == StAcc) && !(last_col && hash_valid_q);
`else
    assign col_ready = (state_q == StAcc);
`endif

    assign col_hs    = col_valid && col_ready;
    // Refill on the last bit of a word so consecutive words stream without a bubble.
    assign din_ready = reset && ((state_q == StIdle) || (col_hs && last_bit && !last_col));
    assign din_hs    = din_valid && din_ready;
    assign hash_hs   = hash_valid_q && hash_ready;
    assign acc_upd   = word_q[b_q] ? (acc_q ^ col) : acc_q;

    assign hash       = hash_q;
    assign hash_valid = hash_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            word_q       <= '0;
            b_q          <= '0;
            j_q          <= '0;
            acc_q        <= '0;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
        end else begin
            if (hash_hs) begin
                hash_valid_q <= 1'b0;
`ifndef TOEPLITZ_ACC_OVERLAP_EN
                acc_q   <= '0;
                state_q <= StIdle;
`endif
            end

            if (din_hs) begin
                word_q  <= din;
                state_q <= StAcc;
            end

            if (col_hs) begin
                b_q <= last_bit ? '0 : b_q + 1'b1;
                j_q <= last_col ? '0 : j_q + 1'b1;
                if (last_col) begin
                    hash_q       <= acc_upd;
                    hash_valid_q <= 1'b1;
                    acc_q        <= '0;
`ifdef TOEPLITZ_ACC_OVERLAP_EN
                    state_q <= StIdle;
`else
                    state_q <= StOut;
`endif
                end else begin
                    acc_q <= acc_upd;
                    if (last_bit && !din_hs) begin
                        state_q <= StIdle;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_toeplitz_acc.sv
// Self-checking bench for toeplitz_acc: small (BS=4,N=8,L=4) and default-parameter instances.
module tb_toeplitz_acc;

    localparam int S_BS = 4;
    localparam int S_N  = 8;
    localparam int S_L  = 4;
    localparam int S_W  = S_N / S_BS;
    localparam int B_BS = 64;
    localparam int B_N  = 256;
    localparam int B_L  = 128;
    localparam int B_W  = B_N / B_BS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [S_BS-1:0] s_din;
    logic            s_din_valid;
    logic            s_din_ready;
    logic [S_L-1:0]  s_col;
    logic            s_col_valid;
    logic            s_col_ready;
    logic [S_L-1:0]  s_hash;
    logic            s_hash_valid;
    logic            s_hash_ready;

    logic [B_BS-1:0] b_din;
    logic            b_din_valid;
    logic            b_din_ready;
    logic [B_L-1:0]  b_col;
    logic            b_col_valid;
    logic            b_col_ready;
    logic [B_L-1:0]  b_hash;
    logic            b_hash_valid;
    logic            b_hash_ready;

    toeplitz_acc #(.BS(S_BS), .N(S_N), .L(S_L)) u_small (
        .clk       (clk),
        .reset     (reset),
        .din       (s_din),
        .din_valid (s_din_valid),
        .din_ready (s_din_ready),
        .col       (s_col),
        .col_valid (s_col_valid),
        .col_ready (s_col_ready),
        .hash      (s_hash),
        .hash_valid(s_hash_valid),
        .hash_ready(s_hash_ready)
    );

    toeplitz_acc u_big (
        .clk       (clk),
        .reset     (reset),
        .din       (b_din),
        .din_valid (b_din_valid),
        .din_ready (b_din_ready),
        .col       (b_col),
        .col_valid (b_col_valid),
        .col_ready (b_col_ready),
        .hash      (b_hash),
        .hash_valid(b_hash_valid),
        .hash_ready(b_hash_ready)
    );

    logic [S_BS-1:0] s_words[S_W];
    logic [S_L-1:0]  s_cols[S_N];
    int              w1_cyc;
    int              c4_cyc;
    logic            hv_pre;

    // Reference: XOR of every column whose input bit is set, bits taken LSB first.
    function automatic logic [S_L-1:0] s_model();
        logic [S_L-1:0] h;
        h = '0;
        for (int j = 0; j < S_N; j++) begin
            if (s_words[j / S_BS][j % S_BS]) h = h ^ s_cols[j];
        end
        return h;
    endfunction

    task automatic drive_block(input int col_limit, input bit rnd, output bit ok);
        int wi;
        int ci;
        int n;
        bit dh;
        bit ch;
        wi = 0;
        ci = 0;
        n = 0;
        w1_cyc = -1;
        c4_cyc = -2;
        hv_pre = 1'bx;
        while ((wi < S_W || ci < col_limit) && n < 200) begin
            s_din       = s_words[(wi < S_W) ? wi : 0];
            s_din_valid = (wi < S_W) && (!rnd || $urandom_range(0, 3) != 0);
            s_col       = s_cols[(ci < S_N) ? ci : 0];
            s_col_valid = (ci < col_limit) && (!rnd || $urandom_range(0, 3) != 0);
            @(negedge clk);
            dh = s_din_valid && s_din_ready;
            ch = s_col_valid && s_col_ready;
            if (dh && wi == 1) w1_cyc = cyc;
            if (ch && ci == 3) c4_cyc = cyc;
            if (ch && ci == S_N - 1) hv_pre = s_hash_valid;
            @(posedge clk);
            #1;
            if (dh) wi++;
            if (ch) ci++;
            n++;
        end
        s_din_valid = 1'b0;
        s_col_valid = 1'b0;
        ok = (wi == S_W) && (ci == col_limit);
    endtask

    task automatic take_hash(input int delay, input logic [S_L-1:0] exp);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            total++;
            if (s_hash_valid !== 1'b1 || s_hash !== exp) begin
                bad++;
                $display("FAIL hold_stable: valid=%b hash=%h, want valid=1 hash=%h",
                         s_hash_valid, s_hash, exp);
            end
            @(posedge clk);
            #1;
        end
        s_hash_ready = 1'b1;
        @(posedge clk);
        #1;
        s_hash_ready = 1'b0;
        total++;
        if (s_hash_valid !== 1'b0) begin
            bad++;
            $display("FAIL hash_valid_clear: got %b want 0", s_hash_valid);
        end
    endtask

    task automatic check_block(input string name, input logic [S_L-1:0] exp, input bit ok);
        total++;
        if (!ok || hv_pre !== 1'b0 || s_hash_valid !== 1'b1 || s_hash !== exp) begin
            bad++;
            $display("FAIL %s: done=%0d early_valid=%b valid=%b hash=%h, want 1/0/1/%h",
                     name, ok, hv_pre, s_hash_valid, s_hash, exp);
        end
    endtask

    task automatic test_reset();
        s_din_valid = 1'b0; s_col_valid = 1'b0; s_hash_ready = 1'b0;
        s_din = '0; s_col = '0;
        b_din_valid = 1'b0; b_col_valid = 1'b0; b_hash_ready = 1'b0;
        b_din = '0; b_col = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        total++;
        if (s_din_ready !== 1'b0 || s_col_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: din_ready=%b col_ready=%b want 0 0", s_din_ready, s_col_ready);
        end
        total++;
        if (s_hash_valid !== 1'b0 || s_hash !== 4'h0 || b_hash_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hash: valid=%b hash=%h big_valid=%b want 0 0 0",
                     s_hash_valid, s_hash, b_hash_valid);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        total++;
        if (s_din_ready !== 1'b1 || s_col_ready !== 1'b0 || b_din_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready: din_ready=%b col_ready=%b big=%b want 1 0 1",
                     s_din_ready, s_col_ready, b_din_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_sparse();
        s_words[0] = 4'h5; s_words[1] = 4'h0;
        for (int j = 0; j < S_N; j++) s_cols[j] = 4'hF;
        s_cols[0] = 4'hA;
        s_cols[2] = 4'h3;
    endtask

    task automatic load_walking(input logic [S_BS-1:0] w);
        s_words[0] = w; s_words[1] = w;
        for (int j = 0; j < S_N; j++) s_cols[j] = 4'(1 << (j % 4));
    endtask

    task automatic test_zero_block();
        bit ok;
        load_walking(4'h0);
        drive_block(S_N, 1'b0, ok);
        check_block("zero_block", 4'h0, ok);
        take_hash(0, 4'h0);
    endtask

    task automatic test_sparse();
        bit ok;
        load_sparse();
        drive_block(S_N, 1'b0, ok);
        check_block("sparse", 4'h9, ok);
        take_hash(2, 4'h9);
    endtask

    task automatic test_back_to_back();
        bit ok;
        load_walking(4'hF);
        drive_block(S_N, 1'b0, ok);
        check_block("all_ones", 4'h0, ok);
        total++;
        if (w1_cyc !== c4_cyc) begin
            bad++;
            $display("FAIL back_to_back: word1 cycle=%0d want col4 cycle=%0d", w1_cyc, c4_cyc);
        end
        take_hash(0, 4'h0);
    endtask

    task automatic test_backpressure();
        bit ok;
        load_sparse();
        drive_block(S_N, 1'b0, ok);
        check_block("bp_block", 4'h9, ok);
        s_din = 4'h5;
        for (int c = 0; c < 5; c++) begin
`ifdef TOEPLITZ_ACC_OVERLAP_EN
            s_din_valid = (c == 0);
            s_col_valid = 1'b0;
`else
            s_din_valid = 1'b1;
            s_col_valid = 1'b1;
`endif
            @(negedge clk);
            total++;
            if (s_hash_valid !== 1'b1 || s_hash !== 4'h9) begin
                bad++;
                $display("FAIL bp_hold c%0d: valid=%b hash=%h want 1 9", c, s_hash_valid, s_hash);
            end
            total++;
`ifdef TOEPLITZ_ACC_OVERLAP_EN
            if ((c == 0 && s_din_ready !== 1'b1) || (c > 0 && s_col_ready !== 1'b1)) begin
                bad++;
                $display("FAIL bp_overlap c%0d: din_ready=%b col_ready=%b want accepting",
                         c, s_din_ready, s_col_ready);
            end
`else
            if (s_col_ready !== 1'b0 || s_din_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall c%0d: din_ready=%b col_ready=%b want 0 0",
                         c, s_din_ready, s_col_ready);
            end
`endif
            @(posedge clk);
            #1;
        end
        s_din_valid = 1'b0;
        s_col_valid = 1'b0;
        take_hash(0, 4'h9);
        @(negedge clk);
        total++;
        if (s_hash_valid !== 1'b0 || s_hash !== 4'h9) begin
            bad++;
            $display("FAIL bp_after: valid=%b hash=%h want 0 9", s_hash_valid, s_hash);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_block();
        bit ok;
        load_sparse();
        drive_block(5, 1'b0, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL partial_block: got done=0 want 1");
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (s_din_ready !== 1'b0 || s_col_ready !== 1'b0 || s_hash_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: din_ready=%b col_ready=%b valid=%b want 0 0 0",
                     s_din_ready, s_col_ready, s_hash_valid);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        total++;
        if (s_din_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_release: din_ready=%b want 1", s_din_ready);
        end
        @(posedge clk);
        #1;
        drive_block(S_N, 1'b0, ok);
        check_block("after_reset", 4'h9, ok);
        take_hash(0, 4'h9);
    endtask

    task automatic test_random();
        bit ok;
        logic [S_L-1:0] exp;
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < S_W; k++) s_words[k] = 4'($urandom());
            for (int j = 0; j < S_N; j++) s_cols[j] = 4'($urandom());
            exp = s_model();
            drive_block(S_N, 1'b1, ok);
            check_block($sformatf("random%0d", t), exp, ok);
            take_hash(int'($urandom_range(0, 3)), exp);
        end
    endtask

    task automatic test_default_params();
        logic [383:0]     seed;
        logic [255:0]     xv;
        logic [B_L-1:0]   exp;
        int wi;
        int ci;
        int n;
        bit dh;
        bit ch;
        for (int i = 0; i < 12; i++) seed[i*32 +: 32] = $urandom();
        xv = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_deadbeefcafef00d;
        exp = '0;
        // Stride-1 Toeplitz: column j is the L-bit window of the seed starting at bit j.
        for (int j = 0; j < B_N; j++) begin
            if (xv[j]) exp = exp ^ seed[j +: B_L];
        end
        wi = 0;
        ci = 0;
        n = 0;
        while ((wi < B_W || ci < B_N) && n < 2000) begin
            b_din       = xv[((wi < B_W) ? wi : 0) * B_BS +: B_BS];
            b_din_valid = (wi < B_W);
            b_col       = seed[((ci < B_N) ? ci : 0) +: B_L];
            b_col_valid = (ci < B_N);
            @(negedge clk);
            dh = b_din_valid && b_din_ready;
            ch = b_col_valid && b_col_ready;
            @(posedge clk);
            #1;
            if (dh) wi++;
            if (ch) ci++;
            n++;
        end
        b_din_valid = 1'b0;
        b_col_valid = 1'b0;
        total++;
        if (wi != B_W || ci != B_N || b_hash_valid !== 1'b1 || b_hash !== exp) begin
            bad++;
            $display("FAIL default_params: words=%0d cols=%0d valid=%b hash=%h want %h",
                     wi, ci, b_hash_valid, b_hash, exp);
        end
        b_hash_ready = 1'b1;
        @(posedge clk);
        #1 b_hash_ready = 1'b0;
        total++;
        if (b_hash_valid !== 1'b0) begin
            bad++;
            $display("FAIL default_params_clear: valid=%b want 0", b_hash_valid);
        end
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_sparse();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_block();
        test_random();
        test_default_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/toeplitz_acc.md
TOEPLITZ_ACC -- requirements
Module: toeplitz_acc

Interface
REQ-001 SHALL have parameter BS, default 64: input data word width in bits.
REQ-002 SHALL have parameter N, default 256: input bits (and Toeplitz columns) per block; N SHALL be a multiple of BS.
REQ-003 SHALL have parameter L, default 128: column and hash width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port din, input, BS: raw data word.
REQ-007 SHALL have port din_valid, input, 1: din holds a valid word.
REQ-008 SHALL have port din_ready, output, 1: din accepted when din_valid && din_ready.
REQ-009 SHALL have port col, input, L: next Toeplitz column, as produced by gencol.
REQ-010 SHALL have port col_valid, input, 1: col is valid.
REQ-011 SHALL have port col_ready, output, 1: col consumed when col_valid && col_ready.
REQ-012 SHALL have port hash, output, L: extracted hash of the last completed block.
REQ-013 SHALL have port hash_valid, output, 1: hash is valid.
REQ-014 SHALL have port hash_ready, input, 1: hash taken when hash_valid && hash_ready.

Function
REQ-015 SHALL compute hash = XOR over j=0..N-1 of (x_j ? col_j : 0), where x_j = din word k bit i, j = k*BS+i (LSB first) and col_j is the j-th column handshake of the block.
REQ-016 SHALL hold one BS-bit word buffer, a bit index b (0..BS-1) and a column counter j (0..N-1, width clog2(N)).
REQ-017 SHALL implement states IDLE (buffer empty, acc=0), ACC (word loaded) and OUT (hash_valid=1).
REQ-018 SHALL assert col_ready only in ACC with a word loaded; each column handshake XORs col into acc if x_j=1, then increments b and j.
REQ-019 SHALL assert din_ready when the buffer is empty, or in the same cycle the buffer's last bit (b=BS-1) is consumed and j<N-1, giving back-to-back words with no bubble.
REQ-020 SHALL NOT accept a column while no word is loaded; col_valid alone SHALL have no effect.
REQ-021 SHALL, on the handshake with j=N-1, load hash with the final acc and assert hash_valid on the next cycle (latency 1), then wrap j and b to 0.
REQ-022 SHALL hold hash and hash_valid stable until hash_ready; on the handshake it SHALL clear hash_valid and clear acc.
REQ-023 SHALL keep din_ready=0 and col_ready=0 in OUT unless TOEPLITZ_ACC_OVERLAP_EN is defined.
REQ-024 SHALL, on a simultaneous hash handshake and din handshake (overlap mode), perform both in that cycle.
REQ-025 SHALL fail elaboration if N mod BS != 0.

Reset
REQ-026 SHALL, while reset=0, asynchronously force IDLE, acc=0, hash=0, hash_valid=0, col_ready=0, din_ready=0, b=0, j=0.
REQ-027 SHALL assert din_ready=1 in the first cycle after reset release; reset mid-block SHALL discard all partial state.

Configuration
REQ-028 SHALL, with TOEPLITZ_ACC_OVERLAP_EN defined, copy acc to a separate hash register on block completion, clear acc and keep accumulating the next block during hash backpressure, stalling (col_ready=0) only when the next block completes while hash_valid is still 1.
REQ-029 SHALL, without TOEPLITZ_ACC_OVERLAP_EN, stall all input in OUT per REQ-023.

Verification (N=8, BS=4, L=4 unless noted)
REQ-030 SHALL verify: din=4'h0,4'h0 with cols 1,2,4,8,1,2,4,8 -> hash=4'h0, hash_valid one cycle after the 8th column.
REQ-031 SHALL verify: din=4'h5,4'h0 with col0=4'hA, col2=4'h3, other cols 4'hF -> hash=4'h9.
REQ-032 SHALL verify: din=4'hF,4'hF with cols 1,2,4,8,1,2,4,8 -> hash=4'h0; the second word is accepted in the cycle of the 4th column handshake.
REQ-033 SHALL verify: hash_ready held 0 for 5 cycles -> hash stable, col_ready=0 throughout (no macro), col_ready=1 (macro defined).
REQ-034 SHALL verify: reset pulsed low after 5 column handshakes, then the REQ-031 block is run -> hash=4'h9.
REQ-035 SHALL verify with the default parameters: hash equals the software Toeplitz product of the gencol STRIDE=1 column stream and a fixed 256-bit input vector.
